// File: rtl/huffman_merge_ctrl.sv
// huffman_merge_ctrl
// Encoding-phase sequencer of the 6-symbol Huffman encoder. On an accepted
// start it latches the six counts into a node table. It then alternates
// FIND (pick the two lightest active slots) and MERGE (extend the codes of
// every symbol under those slots by one bit, then fuse the two slots) until
// one node remains. A registered code_valid pulse marks the final
// hc*/m* values.
//
// Handshake: start is a single-cycle request. It is accepted only when the
// block is idle and not presenting code_valid, which is exactly when
// busy=0. While busy=1 the block drops start without side effects.
// code_valid is a single-cycle pulse with no back-pressure. hc*/m* stay
// stable from that pulse until the next accepted start.
module huffman_merge_ctrl #(
   parameter int CW     = 8,
   parameter int CODE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CW-1:0]     cnt1,
   input  logic [CW-1:0]     cnt2,
   input  logic [CW-1:0]     cnt3,
   input  logic [CW-1:0]     cnt4,
   input  logic [CW-1:0]     cnt5,
   input  logic [CW-1:0]     cnt6,
   output logic              busy,
   output logic              code_valid,
   output logic [CODE_W-1:0] hc1,
   output logic [CODE_W-1:0] hc2,
   output logic [CODE_W-1:0] hc3,
   output logic [CODE_W-1:0] hc4,
   output logic [CODE_W-1:0] hc5,
   output logic [CODE_W-1:0] hc6,
   output logic [CODE_W-1:0] m1,
   output logic [CODE_W-1:0] m2,
   output logic [CODE_W-1:0] m3,
   output logic [CODE_W-1:0] m4,
   output logic [CODE_W-1:0] m5,
   output logic [CODE_W-1:0] m6,
   output logic [1:0]        o_dbg_state
);

   // Three extra weight bits hold the sum of six maximal counts.
   localparam int WW = CW + 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FIND  = 2'd1,
      S_MERGE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   // Node table and per-symbol code construction state
   logic [5:0]        r_active;
   logic [WW-1:0]     r_weight [6];
   logic [5:0]        r_member [6];
   logic [2:0]        r_len    [6];
   logic [CODE_W-1:0] r_hc     [6];
   logic [CODE_W-1:0] r_m      [6];
   logic [2:0]        r_nact;
   logic [2:0]        r_a;
   logic [2:0]        r_b;
   logic              r_code_valid;

   logic [CW-1:0]     w_cnt [6];
   logic              w_accept;
   logic [2:0]        w_nz;
   logic [2:0]        w_find_a;
   logic [2:0]        w_find_b;
   logic              w_found_a;
   logic              w_found_b;
   logic [WW-1:0]     w_best_a;
   logic [WW-1:0]     w_best_b;
   logic [2:0]        w_lo;
   logic [2:0]        w_hi;

   assign w_cnt[0] = cnt1;
   assign w_cnt[1] = cnt2;
   assign w_cnt[2] = cnt3;
   assign w_cnt[3] = cnt4;
   assign w_cnt[4] = cnt5;
   assign w_cnt[5] = cnt6;

   // The code_valid cycle counts as busy, so start is refused there too.
   assign w_accept = start && (r_state == S_IDLE) && !r_code_valid;

   // The merged node lands in the lower slot; the higher slot is freed.
   assign w_lo = (r_a < r_b) ? r_a : r_b;
   assign w_hi = (r_a < r_b) ? r_b : r_a;

   // Count the symbols with a nonzero count at the start request.
   always_comb begin
      w_nz = 3'd0;
      for (int i = 0; i < 6; i++) begin
         w_nz = w_nz + {2'b00, (w_cnt[i] != '0)};
      end
   end

   // Lightest and second-lightest active slot; "<=" makes ties favour the higher index.
   always_comb begin
      w_find_a  = 3'd0;
      w_find_b  = 3'd0;
      w_found_a = 1'b0;
      w_found_b = 1'b0;
      w_best_a  = '0;
      w_best_b  = '0;
      for (int i = 0; i < 6; i++) begin
         if (r_active[i] && (!w_found_a || (r_weight[i] <= w_best_a))) begin
            w_found_a = 1'b1;
            w_best_a  = r_weight[i];
            w_find_a  = 3'(i);
         end
      end
      for (int i = 0; i < 6; i++) begin
         if (r_active[i] && (3'(i) != w_find_a) &&
             (!w_found_b || (r_weight[i] <= w_best_b))) begin
            w_found_b = 1'b1;
            w_best_b  = r_weight[i];
            w_find_b  = 3'(i);
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic: one FIND/MERGE pair per merge round.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next_state = (w_nz >= 3'd2) ? S_FIND : S_DONE;
         end
         S_FIND:  w_next_state = S_MERGE;
         S_MERGE: w_next_state = (r_nact == 3'd2) ? S_DONE : S_FIND;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Node table, code build-up and the registered code_valid pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_active     <= '0;
         r_nact       <= 3'd0;
         r_a          <= 3'd0;
         r_b          <= 3'd0;
         r_code_valid <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            r_weight[i] <= '0;
            r_member[i] <= '0;
            r_len[i]    <= 3'd0;
            r_hc[i]     <= '0;
            r_m[i]      <= '0;
         end
      end else begin
         r_code_valid <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_nact <= w_nz;
                  for (int i = 0; i < 6; i++) begin
                     r_active[i] <= (w_cnt[i] != '0);
                     r_weight[i] <= WW'(w_cnt[i]);
                     r_member[i] <= 6'b000001 << i;
                     r_len[i]    <= 3'd0;
                     r_hc[i]     <= '0;
                     // A lone symbol still needs a one-bit code ("0").
                     r_m[i]      <= ((w_nz == 3'd1) && (w_cnt[i] != '0)) ?
                                    CODE_W'(1) : '0;
                  end
               end
            end
            S_FIND: begin
               r_a <= w_find_a;
               r_b <= w_find_b;
            end
            S_MERGE: begin
               // Lightest subtree takes a 1, the other a 0, at each symbol's next bit.
               for (int s = 0; s < 6; s++) begin
                  if (r_member[r_a][s]) begin
                     r_hc[s][r_len[s]] <= 1'b1;
                     r_m[s][r_len[s]]  <= 1'b1;
                     r_len[s]          <= r_len[s] + 3'd1;
                  end else if (r_member[r_b][s]) begin
                     r_hc[s][r_len[s]] <= 1'b0;
                     r_m[s][r_len[s]]  <= 1'b1;
                     r_len[s]          <= r_len[s] + 3'd1;
                  end
               end
               r_weight[w_lo] <= r_weight[r_a] + r_weight[r_b];
               r_member[w_lo] <= r_member[r_a] | r_member[r_b];
               r_active[w_lo] <= 1'b1;
               r_active[w_hi] <= 1'b0;
               r_nact         <= r_nact - 3'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE) || r_code_valid;
   assign code_valid  = r_code_valid;
   assign o_dbg_state = r_state;

   assign hc1 = r_hc[0];
   assign hc2 = r_hc[1];
   assign hc3 = r_hc[2];
   assign hc4 = r_hc[3];
   assign hc5 = r_hc[4];
   assign hc6 = r_hc[5];
   assign m1  = r_m[0];
   assign m2  = r_m[1];
   assign m3  = r_m[2];
   assign m4  = r_m[3];
   assign m5  = r_m[4];
   assign m6  = r_m[5];

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// tb_huffman_merge_ctrl
// Directed and randomized runs of huffman_merge_ctrl against a list-based
// Huffman reference model kept in this bench.
module tb_huffman_merge_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] cnt1, cnt2, cnt3, cnt4, cnt5, cnt6;
  logic       busy;
  logic       code_valid;
  logic [7:0] hc1, hc2, hc3, hc4, hc5, hc6;
  logic [7:0] m1, m2, m3, m4, m5, m6;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected entry: {hc1..hc6, m1..m6}
  logic [95:0] exp_q[$];

  logic [7:0] cnt_v[6];
  logic [7:0] exp_hc[6];
  logic [7:0] exp_m[6];
  int         exp_lat;

  huffman_merge_ctrl #(.CW(8), .CODE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4), .cnt5(cnt5), .cnt6(cnt6),
    .busy(busy), .code_valid(code_valid),
    .hc1(hc1), .hc2(hc2), .hc3(hc3), .hc4(hc4), .hc5(hc5), .hc6(hc6),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5), .m6(m6),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cnt();
    cnt1 = cnt_v[0]; cnt2 = cnt_v[1]; cnt3 = cnt_v[2];
    cnt4 = cnt_v[3]; cnt5 = cnt_v[4]; cnt6 = cnt_v[5];
  endtask

  task automatic scramble_cnt();
    cnt1 = 8'($urandom); cnt2 = 8'($urandom); cnt3 = 8'($urandom);
    cnt4 = 8'($urandom); cnt5 = 8'($urandom); cnt6 = 8'($urandom);
  endtask

  task automatic set_cnt(input int c0, input int c1, input int c2,
                         input int c3, input int c4, input int c5);
    cnt_v[0] = 8'(c0); cnt_v[1] = 8'(c1); cnt_v[2] = 8'(c2);
    cnt_v[3] = 8'(c3); cnt_v[4] = 8'(c4); cnt_v[5] = 8'(c5);
  endtask

  // Reference model: a list of live nodes, each holding a total weight and
  // the set of symbols beneath it. Repeatedly fuse the two lightest (ties
  // go to the later list position), prepending 1 to every symbol of the
  // lightest node and 0 to every symbol of the other, toward the root.
  task automatic model();
    int w[6];
    logic [5:0] mem[6];
    bit live[6];
    int len[6];
    int n, a, b, lo, hi;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      w[i] = int'(cnt_v[i]);
      live[i] = (cnt_v[i] != 0);
      mem[i] = 6'b000001 << i;
      len[i] = 0;
      exp_hc[i] = 8'h00;
      exp_m[i] = 8'h00;
      if (live[i]) n++;
    end
    if (n == 1) begin
      for (int i = 0; i < 6; i++) if (live[i]) exp_m[i] = 8'h01;
    end
    exp_lat = (n >= 2) ? 2 * (n - 1) + 1 : 1;
    for (int r = 0; r < n - 1; r++) begin
      a = -1;
      for (int i = 0; i < 6; i++) if (live[i] && (a < 0 || w[i] <= w[a])) a = i;
      b = -1;
      for (int i = 0; i < 6; i++) if (live[i] && i != a && (b < 0 || w[i] <= w[b])) b = i;
      for (int s = 0; s < 6; s++) begin
        if (mem[a][s] || mem[b][s]) begin
          if (mem[a][s]) exp_hc[s] = exp_hc[s] | (8'h01 << len[s]);
          exp_m[s] = exp_m[s] | (8'h01 << len[s]);
          len[s]++;
        end
      end
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      w[lo] = w[a] + w[b];
      mem[lo] = mem[a] | mem[b];
      live[lo] = 1'b1;
      live[hi] = 1'b0;
    end
    exp_q.push_back({exp_hc[0], exp_hc[1], exp_hc[2], exp_hc[3], exp_hc[4], exp_hc[5],
                     exp_m[0], exp_m[1], exp_m[2], exp_m[3], exp_m[4], exp_m[5]});
  endtask

  // Compare the ports against the oldest scoreboard entry.
  task automatic score(input string name);
    logic [95:0] e;
    logic [95:0] o;
    if (exp_q.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    o = {hc1, hc2, hc3, hc4, hc5, hc6, m1, m2, m3, m4, m5, m6};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s hc%0d", name, i + 1), 32'(o[95 - 8*i -: 8]), 32'(e[95 - 8*i -: 8]));
      check($sformatf("%s m%0d", name, i + 1),  32'(o[47 - 8*i -: 8]), 32'(e[47 - 8*i -: 8]));
    end
  endtask

  // Driver: issue start with cnt_v, scramble counts afterwards, optionally
  // pulse a second start at cycle inject_at (-2 means the code_valid cycle).
  task automatic run_case(input string name, input int inject_at);
    int inj;
    model();
    inj = (inject_at == -2) ? exp_lat : inject_at;
    @(negedge clk);
    apply_cnt();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= exp_lat; k++) begin
      scramble_cnt();
      start = (k == inj) ? 1'b1 : 1'b0;
      check($sformatf("%s busy k=%0d", name, k), 32'(busy), 32'd1);
      check($sformatf("%s code_valid k=%0d", name, k), 32'(code_valid), 32'(k == exp_lat));
      if (k == exp_lat) score(name);
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " code_valid_drop"}, 32'(code_valid), 32'd0);
    check({name, " busy_drop"}, 32'(busy), 32'd0);
    check({name, " hc_hold"}, 32'({hc1, hc6}), 32'({exp_hc[0], exp_hc[5]}));
  endtask

  function automatic int len_of(input logic [7:0] m);
    return $countones(m);
  endfunction

  initial begin
    logic [7:0] oh[6];
    logic [7:0] om[6];
    int ol[6];
    int cost;
    bit pf_ok;

    start = 1'b0;
    reset = 1'b1;
    set_cnt(0, 0, 0, 0, 0, 0);
    apply_cnt();
    repeat (3) @(negedge clk);

    // Reset state
    check("reset busy", 32'(busy), 32'd0);
    check("reset code_valid", 32'(code_valid), 32'd0);
    check("reset hc", 32'({hc1, hc2, hc3, hc4}), 32'd0);
    check("reset m", 32'({m3, m4, m5, m6}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // One merge round
    set_cnt(5, 0, 0, 0, 0, 3);
    run_case("t1", -1);
    check("t1 hc6 const", 32'(hc6), 32'h01);
    check("t1 m1 const", 32'(m1), 32'h01);

    // Four equal weights
    set_cnt(1, 1, 1, 1, 0, 0);
    run_case("t2", -1);
    check("t2 hc codes", 32'({hc1, hc2, hc3, hc4}), 32'h00010203);
    check("t2 m codes", 32'({m1, m2, m3, m4}), 32'h03030303);

    // Single symbol and empty histogram
    set_cnt(0, 0, 7, 0, 0, 0);
    run_case("t3a", -1);
    check("t3a m3 const", 32'(m3), 32'h01);
    set_cnt(0, 0, 0, 0, 0, 0);
    run_case("t3b", -1);

    // Skewed weights
    set_cnt(1, 2, 4, 8, 16, 32);
    run_case("t4", -1);
    oh[0] = hc1; oh[1] = hc2; oh[2] = hc3; oh[3] = hc4; oh[4] = hc5; oh[5] = hc6;
    om[0] = m1;  om[1] = m2;  om[2] = m3;  om[3] = m4;  om[4] = m5;  om[5] = m6;
    cost = 0;
    for (int i = 0; i < 6; i++) begin
      ol[i] = len_of(om[i]);
      cost += int'(cnt_v[i]) * ol[i];
    end
    check("t4 lengths", 32'({4'(ol[0]), 4'(ol[1]), 4'(ol[2]), 4'(ol[3]), 4'(ol[4]), 4'(ol[5])}),
          32'h00554321);
    check("t4 cost", 32'(cost), 32'd119);
    // Codes are read root-first from the top masked bit.
    pf_ok = 1'b1;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        if (i != j && ol[i] <= ol[j] && ol[i] > 0)
          if ((oh[j] >> (ol[j] - ol[i])) == oh[i]) pf_ok = 1'b0;
    check("t4 prefix_free", 32'(pf_ok), 32'd1);

    // Weight-width boundary: all counts maximal
    set_cnt(255, 255, 255, 255, 255, 255);
    run_case("max", -1);

    // Start during a run and during the code_valid cycle are ignored
    set_cnt(3, 9, 0, 2, 6, 1);
    run_case("t5_mid", 2);
    set_cnt(4, 4, 0, 0, 1, 0);
    run_case("t5_cv", -2);
    // Next start is accepted and clears earlier codes
    set_cnt(0, 0, 0, 0, 0, 0);
    run_case("t5_clear", -1);

    // Reset during a MERGE cycle
    set_cnt(1, 1, 1, 1, 0, 0);
    @(negedge clk);
    apply_cnt();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 busy", 32'(busy), 32'd0);
    check("t6 code_valid", 32'(code_valid), 32'd0);
    check("t6 hc", 32'({hc1, hc2, hc3, hc4}), 32'd0);
    check("t6 m", 32'({m1, m2, m3, m4}), 32'd0);

    // Start coincident with reset: reset wins
    set_cnt(2, 3, 0, 0, 0, 0);
    apply_cnt();
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("t6 start_with_reset busy", 32'(busy), 32'd0);
    check("t6 start_with_reset code_valid", 32'(code_valid), 32'd0);

    // Fresh run after the abort
    set_cnt(1, 1, 1, 1, 0, 0);
    run_case("t6_fresh", -1);

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 6; i++)
        cnt_v[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (r == 5) for (int i = 0; i < 6; i++) cnt_v[i] = 8'($urandom_range(1, 3));
      run_case($sformatf("rnd%0d", r), (r % 3 == 0) ? 1 : -1);
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
